// File: rtl/cdma_lite_slave.sv
// +--------------------------------------------------------------------+
// | cdma_lite_slave: AXI-Lite programmed word-copy engine (SA/DA/BTT)  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module cdma_lite_slave (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  awaddr_i,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [31:0] wdata_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i,
   output logic        xfer_valid_o,
   output logic [31:0] xfer_src_o,
   output logic [31:0] xfer_dst_o,
   input  logic        xfer_ready_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        done_pulse_o
);

   localparam logic [9:0] c_ADDR_SR  = 10'h004;
   localparam logic [9:0] c_ADDR_SA  = 10'h018;
   localparam logic [9:0] c_ADDR_DA  = 10'h020;
   localparam logic [9:0] c_ADDR_BTT = 10'h028;
   localparam logic [1:0] c_OKAY     = 2'b00;
   localparam logic [1:0] c_SLVERR   = 2'b10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] sa_q, sa_d;
   logic [31:0] da_q, da_d;
   logic [25:0] btt_q, btt_d;
   logic [31:0] cur_src_q, cur_src_d;
   logic [31:0] cur_dst_q, cur_dst_d;
   logic [23:0] words_q, words_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic        done_q, done_d;
   logic        done_pulse_q, done_pulse_d;

   logic        w_busy;
   logic        w_accept;
   logic        w_hit_sr, w_hit_sa, w_hit_da, w_hit_btt, w_hit_cfg;
   logic        w_err;
   logic        w_wr_ok;
   logic        w_fire;
   logic        w_last;
   logic        w_start;
   logic [26:0] w_btt_round;

   assign w_busy    = (state_q == ST_RUN);
   assign w_accept  = awvalid_i & wvalid_i & ~bvalid_q;
   assign w_hit_sr  = (awaddr_i == c_ADDR_SR);
   assign w_hit_sa  = (awaddr_i == c_ADDR_SA);
   assign w_hit_da  = (awaddr_i == c_ADDR_DA);
   assign w_hit_btt = (awaddr_i == c_ADDR_BTT);
   assign w_hit_cfg = w_hit_sa | w_hit_da | w_hit_btt;
   // Misaligned offsets never match a map entry, so they fall into the unmapped case.
   assign w_err     = (awaddr_i[1:0] != 2'b00) | ~(w_hit_sr | w_hit_cfg) | (w_hit_cfg & w_busy);
   assign w_wr_ok   = w_accept & ~w_err;
   assign w_fire    = w_busy & xfer_ready_i;
   assign w_last    = w_fire & (words_q == 24'd1);
   assign w_start   = w_wr_ok & w_hit_btt & (wdata_i[25:0] != 26'd0);
   assign w_btt_round = {1'b0, btt_d} + 27'd3;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_start) state_d = ST_RUN;
         ST_RUN:  if (w_last)  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      sa_d         = sa_q;
      da_d         = da_q;
      btt_d        = btt_q;
      cur_src_d    = cur_src_q;
      cur_dst_d    = cur_dst_q;
      words_d      = words_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      done_pulse_d = w_last;
      done_d       = done_q;

      if (w_accept) begin
         bvalid_d = 1'b1;
         bresp_d  = w_err ? c_SLVERR : c_OKAY;
      end else if (bvalid_q & bready_i) begin
         bvalid_d = 1'b0;
      end

      if (w_wr_ok & w_hit_sa)  sa_d  = wdata_i;
      if (w_wr_ok & w_hit_da)  da_d  = wdata_i;
      if (w_wr_ok & w_hit_btt) btt_d = wdata_i[25:0];

      if (w_start) begin
         cur_src_d = sa_q;
         cur_dst_d = da_q;
         words_d   = w_btt_round[25:2];
      end else if (w_fire) begin
         cur_src_d = cur_src_q + 32'd4;
         cur_dst_d = cur_dst_q + 32'd4;
         words_d   = words_q - 24'd1;
      end

      // A completion landing in the same cycle as a clear keeps done set.
      if (w_wr_ok & w_hit_sr & wdata_i[1]) done_d = 1'b0;
      if (w_last)                          done_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         sa_q         <= '0;
         da_q         <= '0;
         btt_q        <= '0;
         cur_src_q    <= '0;
         cur_dst_q    <= '0;
         words_q      <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= c_OKAY;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         sa_q         <= sa_d;
         da_q         <= da_d;
         btt_q        <= btt_d;
         cur_src_q    <= cur_src_d;
         cur_dst_q    <= cur_dst_d;
         words_q      <= words_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         done_q       <= done_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   assign awready_o    = ~bvalid_q;
   assign wready_o     = ~bvalid_q;
   assign bvalid_o     = bvalid_q;
   assign bresp_o      = bresp_q;
   assign xfer_valid_o = w_busy;
   assign xfer_src_o   = cur_src_q;
   assign xfer_dst_o   = cur_dst_q;
   assign busy_o       = w_busy;
   assign done_o       = done_q;
   assign done_pulse_o = done_pulse_q;

endmodule

`default_nettype wire
